// File: rtl/scmemctrl.sv
// Load/store controller: turns byte/half/word CPU accesses into aligned word
// accesses, with lane extraction for loads and read-modify-write for stores.
module scmemctrl (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);

    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state;
    logic        wr_p0;
    logic        sext_p0;
    logic [1:0]  size_p0;
    logic [1:0]  lane_p0;
    logic [31:0] wdata_p0;
    logic        illegal;

    // Pick the addressed lane out of a little-endian word and widen it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  lane,
                                                 input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        h = 16'h0000;
        r = word;
        case (sz)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    b = word[7:0];
                    2'd1:    b = word[15:8];
                    2'd2:    b = word[23:16];
                    default: b = word[31:24];
                endcase
                r = sx ? {{24{b[7]}}, b} : {24'h000000, b};
            end
            SZ_HALF: begin
                h = lane[1] ? word[31:16] : word[15:0];
                r = sx ? {{16{h[15]}}, h} : {16'h0000, h};
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay right-justified store data onto the addressed lane of a word.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  lane);
        logic [31:0] m;
        m = word;
        case (sz)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    m[7:0]   = data[7:0];
                    2'd1:    m[15:8]  = data[7:0];
                    2'd2:    m[23:16] = data[7:0];
                    default: m[31:24] = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1])
                    m[31:16] = data[15:0];
                else
                    m[15:0] = data[15:0];
            end
            default: m = data;
        endcase
        return m;
    endfunction

    assign illegal = (size == 2'b11)
                  || (size == SZ_HALF && addr[0])
                  || (size == SZ_WORD && addr[1:0] != 2'b00);

    // Decoded from state so an asynchronous reset during WR kills the write at once.
    assign mem_we = (state == WR);

    // Request capture at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            wr_p0    <= wr;
            sext_p0  <= sext;
            size_p0  <= size;
            lane_p0  <= addr[1:0];
            wdata_p0 <= wdata;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            rdata      <= 32'h0000_0000;
            mem_addr   <= 32'h0000_0000;
            mem_datain <= 32'h0000_0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        mem_addr <= {addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (illegal) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (wr_p0) begin
                        mem_datain <= store_merge(mem_dataout, wdata_p0, size_p0, lane_p0);
                        state      <= WR;
                    end else begin
                        rdata <= load_extract(mem_dataout, size_p0, lane_p0, sext_p0);
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WR: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scmemctrl.sv
// Directed bench for scmemctrl: a word memory model plus a table of load/store
// vectors, followed by hand-written held-request and reset-during-write sequences.
module tb_scmemctrl;

    logic        clk;
    logic        clrn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic [31:0] mem_dataout;

    logic [31:0] mem [32];
    logic        ld_en;
    logic [4:0]  ld_idx;
    logic [31:0] ld_val;

    int n_checks;
    int n_fail;

    scmemctrl dut (
        .clk        (clk),
        .clrn       (clrn),
        .req        (req),
        .wr         (wr),
        .size       (size),
        .sext       (sext),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .mem_we     (mem_we),
        .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dataout = mem[mem_addr[6:2]];

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_idx] <= ld_val;
        else if (mem_we)
            mem[mem_addr[6:2]] <= mem_datain;
    end

    typedef struct packed {
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [3:0]  exp_done;
        logic        exp_err;
        logic [3:0]  exp_we;
        logic [31:0] chk_addr;
        logic [31:0] chk_word;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp_rd, input logic [3:0] exp_done,
                                input logic exp_err, input logic [3:0] exp_we,
                                input logic [31:0] chk_addr, input logic [31:0] chk_word);
        vec_t v;
        v.w = w; v.sz = sz; v.sx = sx; v.a = a; v.d = d;
        v.exp_rd = exp_rd; v.exp_done = exp_done; v.exp_err = exp_err;
        v.exp_we = exp_we; v.chk_addr = chk_addr; v.chk_word = chk_word;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [4:0] idx, input logic [31:0] val);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_val = val;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // Called #1 after a rising edge with the DUT idle; returns in the same phase, idle again.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output int done_cyc, output logic e, output int we_cnt,
                          output logic [31:0] we_addr, output logic [31:0] we_data,
                          output logic proto_bad);
        req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = d;
        done_cyc = -1; e = 1'b0; we_cnt = 0; we_addr = '0; we_data = '0; proto_bad = 1'b0;
        for (int c = 1; c <= 8 && done_cyc < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                req = 1'b0; wr = ~w; size = ~sz; sext = ~sx;
                addr = 32'hdead_beef; wdata = 32'h5555_aaaa;
            end
            if (!busy) proto_bad = 1'b1;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_datain;
            end
            if (done) begin
                done_cyc = c;
                e = err;
            end
        end
        @(posedge clk);
        #1;
        if (busy || done || err || mem_we) proto_bad = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          dc;
        logic        e;
        int          wc;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        pb;
        access(v.w, v.sz, v.sx, v.a, v.d, dc, e, wc, wa, wd, pb);
        check({tag, ".done_cycle"}, 32'(dc), 32'(v.exp_done));
        check({tag, ".err"}, 32'(e), 32'(v.exp_err));
        check({tag, ".we_cycles"}, 32'(wc), 32'(v.exp_we));
        check({tag, ".rdata"}, rdata, v.exp_rd);
        check({tag, ".mem_word"}, mem[v.chk_addr[6:2]], v.chk_word);
        check({tag, ".busy_protocol"}, 32'(pb), 32'd0);
        if (v.exp_we != 4'd0) begin
            check({tag, ".we_addr"}, wa, {v.a[31:2], 2'b00});
            check({tag, ".we_data"}, wd, v.chk_word);
        end
    endtask

    vec_t vt [18];
    vec_t vr [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] busy_v;
        logic [7:0] done_v;
        logic [7:0] we_v;
        logic [7:0] err_v;

        n_checks = 0;
        n_fail   = 0;
        clrn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
        addr = '0; wdata = '0; ld_en = 1'b0; ld_idx = '0; ld_val = '0;

        //  w  sz    sx    addr      wdata         rdata        dc  err  we  chk addr  chk word
        vt[0]  = mk(0, 2'b00, 1, 32'h50, 32'h0,         32'hffffffa3, 2, 0, 0, 32'h50, 32'h000000a3);
        vt[1]  = mk(0, 2'b00, 0, 32'h50, 32'h0,         32'h000000a3, 2, 0, 0, 32'h50, 32'h000000a3);
        vt[2]  = mk(1, 2'b00, 0, 32'h55, 32'hffffff5a,  32'h000000a3, 3, 0, 1, 32'h54, 32'h00005a27);
        vt[3]  = mk(0, 2'b10, 0, 32'h54, 32'h0,         32'h00005a27, 2, 0, 0, 32'h54, 32'h00005a27);
        vt[4]  = mk(1, 2'b01, 0, 32'h5a, 32'h1234beef,  32'h00005a27, 3, 0, 1, 32'h58, 32'hbeef0079);
        vt[5]  = mk(0, 2'b01, 1, 32'h5a, 32'h0,         32'hffffbeef, 2, 0, 0, 32'h58, 32'hbeef0079);
        vt[6]  = mk(0, 2'b01, 0, 32'h58, 32'h0,         32'h00000079, 2, 0, 0, 32'h58, 32'hbeef0079);
        vt[7]  = mk(0, 2'b10, 0, 32'h52, 32'h0,         32'h00000079, 1, 1, 0, 32'h50, 32'h000000a3);
        vt[8]  = mk(1, 2'b01, 0, 32'h55, 32'hffff,      32'h00000079, 1, 1, 0, 32'h54, 32'h00005a27);
        vt[9]  = mk(0, 2'b11, 0, 32'h50, 32'h0,         32'h00000079, 1, 1, 0, 32'h50, 32'h000000a3);
        vt[10] = mk(1, 2'b11, 0, 32'h50, 32'hffffffff,  32'h00000079, 1, 1, 0, 32'h50, 32'h000000a3);
        vt[11] = mk(0, 2'b00, 1, 32'h5b, 32'h0,         32'hffffffbe, 2, 0, 0, 32'h58, 32'hbeef0079);
        vt[12] = mk(0, 2'b00, 0, 32'h5a, 32'h0,         32'h000000ef, 2, 0, 0, 32'h58, 32'hbeef0079);
        vt[13] = mk(1, 2'b00, 0, 32'h53, 32'h80,        32'h000000ef, 3, 0, 1, 32'h50, 32'h800000a3);
        vt[14] = mk(0, 2'b10, 0, 32'h50, 32'h0,         32'h800000a3, 2, 0, 0, 32'h50, 32'h800000a3);
        vt[15] = mk(0, 2'b01, 1, 32'h52, 32'h0,         32'hffff8000, 2, 0, 0, 32'h50, 32'h800000a3);
        vt[16] = mk(1, 2'b10, 0, 32'h50, 32'hcafef00d,  32'hffff8000, 3, 0, 1, 32'h50, 32'hcafef00d);
        vt[17] = mk(0, 2'b01, 0, 32'h50, 32'h0,         32'h0000f00d, 2, 0, 0, 32'h50, 32'hcafef00d);

        vr[0] = mk(0, 2'b10, 0, 32'h5c, 32'h0,          32'h0badf00d, 2, 0, 0, 32'h5c, 32'h0badf00d);
        vr[1] = mk(1, 2'b10, 0, 32'h5c, 32'h12345678,   32'h0badf00d, 3, 0, 1, 32'h5c, 32'h12345678);
        vr[2] = mk(0, 2'b10, 0, 32'h5c, 32'h0,          32'h12345678, 2, 0, 0, 32'h5c, 32'h12345678);

        // Preload memory while the controller is held in reset.
        poke(5'd20, 32'h000000a3);
        poke(5'd21, 32'h00000027);
        poke(5'd22, 32'h00000079);
        poke(5'd23, 32'h0badf00d);

        check("reset.rdata",      rdata,              32'h0);
        check("reset.mem_addr",   mem_addr,           32'h0);
        check("reset.mem_datain", mem_datain,         32'h0);
        check("reset.ctrl",       {28'h0, busy, done, err, mem_we}, 32'h0);

        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++)
            run_vec(vt[i], $sformatf("vec%0d", i));

        // Request held high across two stores: second accepted after DONE plus one idle cycle.
        busy_v = '0; done_v = '0; we_v = '0; err_v = '0;
        req = 1'b1; wr = 1'b1; size = 2'b10; sext = 1'b0; addr = 32'h40; wdata = 32'h11111111;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                addr  = 32'h44;
                wdata = 32'h22222222;
            end
            if (c == 5) req = 1'b0;
            busy_v[c-1] = busy;
            done_v[c-1] = done;
            we_v[c-1]   = mem_we;
            err_v[c-1]  = err;
        end
        check("hold.busy_cycles", 32'(busy_v), 32'h77);
        check("hold.done_cycles", 32'(done_v), 32'h44);
        check("hold.we_cycles",   32'(we_v),   32'h22);
        check("hold.err_cycles",  32'(err_v),  32'h00);
        check("hold.word40",      mem[16],     32'h11111111);
        check("hold.word44",      mem[17],     32'h22222222);
        check("hold.rdata",       rdata,       32'h0000f00d);

        // Reset asserted in the middle of the WR cycle.
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h5c; wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("rstwr.we_before", 32'(mem_we), 32'd1);
        #2;
        clrn = 1'b0;
        #1;
        check("rstwr.we_after",     32'(mem_we), 32'd0);
        check("rstwr.ctrl",         {29'h0, busy, done, err}, 32'h0);
        check("rstwr.rdata",        rdata,      32'h0);
        check("rstwr.mem_addr",     mem_addr,   32'h0);
        check("rstwr.mem_datain",   mem_datain, 32'h0);
        @(posedge clk);
        #2;
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check("rstwr.word_kept", mem[23], 32'h0badf00d);

        for (int i = 0; i < 3; i++)
            run_vec(vr[i], $sformatf("post%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scmemctrl.md
# scmemctrl

Load/store controller that sits between the single-cycle CPU datapath and the word-organised data memory. Accepts byte, halfword and word load/store requests at any byte address and converts them into aligned word accesses. Sub-word loads use lane extraction with sign or zero extension; sub-word stores use read-modify-write. The block is the initiating side of the data-memory interface: it drives address, write data and write enable, and consumes the memory's combinational read data.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- clrn  in  1  asynchronous active-low reset.
- req  in  1  CPU access request, sampled only in IDLE.
- wr  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address of the access.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rdata  out  32  registered load result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle misalignment/illegal-size pulse, coincident with done.
- mem_addr  out  32  word-aligned byte address to memory; memory indexes it with [6:2].
- mem_datain  out  32  merged word to write.
- mem_we  out  1  memory write enable; the memory writes on the rising edge that ends the cycle.
- mem_dataout  in  32  combinational read data for the word at mem_addr.

## Operation
- Memory is little-endian. Byte lane k = addr[1:0] occupies bits [8k+7:8k]. The halfword lane is addr[1]: 0 selects [15:0], 1 selects [31:16].
- States: IDLE, RD, WR, DONE, ERR.
- **IDLE**
  - With req=1, latch wr, size, sext, wdata and addr[1:0]; load mem_addr with {addr[31:2],2'b00}.
  - Illegal access goes to ERR: size=11, half with addr[0]=1, or word with addr[1:0]≠00.
  - Any other request goes to RD.
  - With req=0, stay in IDLE.
- **RD**
  - Sample mem_dataout.
  - Load: rdata <= extracted lane, extended per sext to 32 bits; word loads pass through unchanged. Go to DONE.
  - Store: mem_datain <= mem_dataout with the selected lane replaced by wdata[7:0], wdata[15:0], or the whole wdata[31:0]. Go to WR.
- **WR**: mem_we=1 (decoded from state, not registered). Go to DONE.
- **DONE**: done=1. Go to IDLE.
- **ERR**: done=1, err=1. No memory write; rdata holds its previous value. Go to IDLE.
- mem_we is 0 in every state other than WR.
- rdata changes only on completion of a load. Stores leave it unchanged.

## Timing
- Reset values: state IDLE; rdata, mem_addr and mem_datain 0; busy, done, err and mem_we 0.
- clrn low acts immediately, independent of clk. It cancels any in-flight access; if asserted during WR, mem_we drops at once and no write occurs.
- Cycle 0 is the cycle with req=1 in IDLE.
- Load: RD in cycle 1; done and valid rdata in cycle 2.
- Store: RD in cycle 1, WR in cycle 2; memory is updated at the end of cycle 2; done in cycle 3.
- Illegal access: err and done in cycle 1.
- req is ignored while busy=1, including the DONE cycle. If req is held high, the next access is accepted in the first IDLE cycle after DONE, so there is one idle bubble between accesses.
- addr, wdata, wr, size and sext may change after cycle 0; only the latched copies are used.
- mem_addr is stable from cycle 1 until the next acceptance.

## Test plan
- Memory word 0x50 = 0x000000a3.
  - lb at 0x50 with sext=1: rdata=0xffffffa3, done in cycle 2, mem_we never high.
  - Same access with sext=0: rdata=0x000000a3.
- Memory word 0x54 = 0x00000027. sb 0x5a at 0x55: a single one-cycle mem_we pulse in cycle 2 with mem_addr=0x54 and mem_datain=0x00005a27. A following lw at 0x54 returns 0x00005a27.
- Memory word 0x58 = 0x00000079.
  - sh 0xbeef at 0x5a: word becomes 0xbeef0079.
  - lh at 0x5a with sext=1: 0xffffbeef.
  - lhu at 0x58: 0x00000079.
- Illegal accesses:
  - lw at 0x52: err=done=1 in cycle 1, rdata unchanged, no write.
  - sh at 0x55: same response.
  - size=11: same response.
- req held high with two different sw requests: second accepted only after DONE plus one IDLE cycle; both words written correctly; busy never drops mid-access.
- clrn pulsed low during WR of sw 0x12345678 at 0x5c: mem_we falls asynchronously, word unchanged, all outputs 0, next access proceeds normally.
